piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 118 +++++++++++
 tb/tb_piso_serializer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with a valid/ready load
// handshake. Each accepted word is sent one bit per clock with sout_valid set,
// and done marks the final bit of the frame. A word offered during the done
// cycle is loaded straight away, so frames can run back to back with no gap.
// Define PISO_PARITY_EN to append an even-parity bit, making frames WIDTH+1
// bits long.
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] din,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(FRAME - 1);
`ifdef PISO_PARITY_EN
   localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`endif

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   shift_reg, shift_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   logic               sout_reg, sout_next;
   logic               sout_valid_reg, sout_valid_next;
   logic               accept;
   logic               next_bit;
`ifdef PISO_PARITY_EN
   logic               parity_reg, parity_next;
`endif

   // State register. The bit currently on the line is held in sout_reg, and
   // shift_reg holds only the bits still to be sent.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg      <= IDLE;
         shift_reg      <= '0;
         cnt_reg        <= '0;
         sout_reg       <= 1'b0;
         sout_valid_reg <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_reg     <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         shift_reg      <= shift_next;
         cnt_reg        <= cnt_next;
         sout_reg       <= sout_next;
         sout_valid_reg <= sout_valid_next;
`ifdef PISO_PARITY_EN
         parity_reg     <= parity_next;
`endif
      end
   end

   // Next-state logic. load_ready is derived from state and counter only, so
   // it never depends on load_valid.
   always_comb begin
      state_next      = state_reg;
      shift_next      = shift_reg;
      cnt_next        = cnt_reg;
      sout_next       = sout_reg;
      sout_valid_next = sout_valid_reg;
`ifdef PISO_PARITY_EN
      parity_next     = parity_reg;
`endif

      done       = (state_reg == SHIFT) && (cnt_reg == LAST_BIT);
      load_ready = (state_reg == IDLE) || done;
      accept     = load_valid && load_ready;

      next_bit = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
`ifdef PISO_PARITY_EN
      if (cnt_reg == LAST_DATA)
         next_bit = parity_reg;
`endif

      if (accept) begin
         // The first bit goes straight to the output register, and the rest
         // of the word waits in shift_reg.
         state_next      = SHIFT;
         cnt_next        = '0;
         sout_valid_next = 1'b1;
         sout_next       = LSB_FIRST ? din[0] : din[WIDTH-1];
         shift_next      = LSB_FIRST ? (din >> 1) : (din << 1);
`ifdef PISO_PARITY_EN
         parity_next     = ^din;
`endif
      end else if (state_reg == SHIFT) begin
         if (done) begin
            state_next      = IDLE;
            sout_next       = 1'b0;
            sout_valid_next = 1'b0;
         end else begin
            cnt_next   = cnt_reg + CW'(1);
            sout_next  = next_bit;
            shift_next = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
         end
      end
   end

   assign sout       = sout_reg;
   assign sout_valid = sout_valid_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an LSB-first and an MSB-first instance from the
// same inputs. A queue-based model predicts every output cycle by cycle: each
// accepted word adds its frame bits to a queue, and one bit is consumed per clock.
module tb_piso_serializer;
   localparam int WIDTH = 4;
`ifdef PISO_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             clr = 1'b0;
   logic             load_valid = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             l_ready, l_sout, l_valid, l_done;
   logic             m_ready, m_sout, m_valid, m_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic b;
      logic last;
   } fbit_t;

   fbit_t q_l[$];
   fbit_t q_m[$];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(l_ready),
      .din(din), .sout(l_sout), .sout_valid(l_valid), .done(l_done)
   );

   piso_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .clr(clr), .load_valid(load_valid), .load_ready(m_ready),
      .din(din), .sout(m_sout), .sout_valid(m_valid), .done(m_done)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   // Queue front is the bit expected on the line this cycle.
   task automatic check_all(input string ctx);
      logic eb, ev, ed, er;
      if (q_l.size() == 0) begin
         eb = 0; ev = 0; ed = 0; er = 1;
      end else begin
         eb = q_l[0].b; ev = 1; ed = q_l[0].last; er = q_l[0].last;
      end
      chk({ctx, " lsb.sout"}, l_sout, eb);
      chk({ctx, " lsb.valid"}, l_valid, ev);
      chk({ctx, " lsb.done"}, l_done, ed);
      chk({ctx, " lsb.ready"}, l_ready, er);
      if (q_m.size() == 0) begin
         eb = 0; ev = 0; ed = 0; er = 1;
      end else begin
         eb = q_m[0].b; ev = 1; ed = q_m[0].last; er = q_m[0].last;
      end
      chk({ctx, " msb.sout"}, m_sout, eb);
      chk({ctx, " msb.valid"}, m_valid, ev);
      chk({ctx, " msb.done"}, m_done, ed);
      chk({ctx, " msb.ready"}, m_ready, er);
   endtask

   task automatic push_frame(input logic [WIDTH-1:0] w);
      for (int i = 0; i < FRAME; i++) begin
         logic bl, bm;
         if (i < WIDTH) begin
            bl = w[i];
            bm = w[WIDTH-1-i];
         end else begin
            bl = ^w;
            bm = ^w;
         end
         q_l.push_back('{b: bl, last: (i == FRAME - 1)});
         q_m.push_back('{b: bm, last: (i == FRAME - 1)});
      end
   endtask

   // One clock: drive inputs, predict the handshake, advance the model, then check.
   task automatic step(input string ctx, input logic lv, input logic [WIDTH-1:0] d);
      logic acc;
      load_valid = lv;
      din        = d;
      acc = lv && (q_l.size() <= 1);
      @(posedge clk);
      if (q_l.size() != 0) void'(q_l.pop_front());
      if (q_m.size() != 0) void'(q_m.pop_front());
      if (acc) push_frame(d);
      #1;
      check_all(ctx);
      $display("step %-8s lv=%b din=%b | lsb sout=%b v=%b d=%b r=%b | msb sout=%b v=%b d=%b r=%b",
               ctx, lv, d, l_sout, l_valid, l_done, l_ready, m_sout, m_valid, m_done, m_ready);
   endtask

   // Pulse clr between clock edges and check that the outputs clear immediately.
   task automatic do_clr(input string ctx);
      clr = 1'b1;
      #1;
      q_l.delete();
      q_m.delete();
      check_all(ctx);
      $display("clr  %-8s lsb v=%b r=%b | msb v=%b r=%b", ctx, l_valid, l_ready, m_valid, m_ready);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #1;
      do_clr("por");
      @(posedge clk);
      #1;
      check_all("idle");

      // Single frame, followed by idle cycles.
      step("single", 1'b1, 4'b1011);
      for (int i = 0; i < FRAME + 1; i++) step("single", 1'b0, 4'b0000);

      // Back-to-back frames with load_valid held.
      step("b2b", 1'b1, 4'b0001);
      for (int i = 0; i < FRAME - 1; i++) step("b2b", 1'b1, 4'b1110);
      for (int i = 0; i < FRAME + 1; i++) step("b2b", 1'b0, 4'b0000);

      // A new word offered while busy is taken only in the done cycle. A mid-frame clr then discards it.
      step("busy", 1'b1, 4'b1111);
      for (int i = 0; i < FRAME + 1; i++) step("busy", 1'b1, 4'b0110);
      do_clr("midclr");
      for (int i = 0; i < 3; i++) step("postclr", 1'b0, 4'b0110);

      // Parity check word.
      step("par", 1'b1, 4'b0011);
      for (int i = 0; i < FRAME + 1; i++) step("par", 1'b0, 4'b0000);

      // Random traffic with occasional clr.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) do_clr("rclr");
         step("rand", $urandom_range(0, 3) != 0, WIDTH'($urandom));
      end
      for (int i = 0; i < FRAME + 1; i++) step("drain", 1'b0, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
